syscall_unit: RTL

Services the `sys` indication from the control decoder: when a SYSCALL reaches the execute stage, this block reads `$v0`/`$a0`, holds the pipeline with `stall`, and performs the service. Services are print integer as signed decimal ASCII, print character, and exit. Output bytes leave on a valid/ready byte stream to the console model. Exit raises a sticky `halt`. It sits beside the EX stage and is the responder to the decoder's `sys` output.

---
 rtl/syscall_unit_pkg.sv | 54 +++++
 rtl/syscall_unit_bin2bcd.sv | 49 ++++
 rtl/syscall_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/syscall_unit_pkg.sv
// Shared constants, state encoding and BCD helpers for the SYSCALL service unit.
// Service codes follow the MIPS/SPIM convention used by the rest of the core.
package syscall_unit_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned BCD_DIGITS = 10;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned CNT_W      = 6;

  localparam logic [DATA_W-1:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [DATA_W-1:0] SYS_EXIT       = 32'd10;
  localparam logic [DATA_W-1:0] SYS_PRINT_CHAR = 32'd11;

  localparam logic [BYTE_W-1:0] ASCII_ZERO  = 8'h30;
  localparam logic [BYTE_W-1:0] ASCII_MINUS = 8'h2D;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONV   = 3'd1,
    ST_SIGN   = 3'd2,
    ST_DIGITS = 3'd3,
    ST_CHAR   = 3'd4,
    ST_DONE   = 3'd5,
    ST_HALTED = 3'd6
  } state_t;

  // Select one BCD digit by index; out-of-range indices read as zero.
  function automatic logic [3:0] bcd_digit(input logic [BCD_W-1:0] bcd,
                                           input logic [IDX_W-1:0] idx);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (idx == IDX_W'(i)) d = bcd[4*i +: 4];
    end
    return d;
  endfunction

  // Highest nonzero digit position, or 0 when the whole value is zero.
  function automatic logic [IDX_W-1:0] top_index(input logic [BCD_W-1:0] bcd);
    logic [IDX_W-1:0] t;
    t = '0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) t = IDX_W'(i);
    end
    return t;
  endfunction

  function automatic logic [BYTE_W-1:0] ascii_digit(input logic [3:0] d);
    return ASCII_ZERO + {4'd0, d};
  endfunction

endpackage

// File: rtl/syscall_unit_bin2bcd.sv
// Serial double-dabble: 32-bit binary to 10 BCD digits, one shift per cycle.
// Built only when SYSCALL_PRINT_INT_EN is defined; bcd is final while done=1.
`ifdef SYSCALL_PRINT_INT_EN
module bin2bcd_serial
  import syscall_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] value,
  output logic [BCD_W-1:0]  bcd,
  output logic              done
);

  logic [DATA_W-1:0] bin_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  bcd_adj;
  logic [CNT_W-1:0]  cnt_q;

  // Add-3 correction on every digit that is 5 or more before the next shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // The first shift happens on the start edge (digits are zero, so no
  // correction is needed), which leaves the result ready in the 32nd cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      bcd_q <= {(BCD_W-1)'(0), value[DATA_W-1]};
      bin_q <= {value[DATA_W-2:0], 1'b0};
      cnt_q <= CNT_W'(1);
    end else if ((cnt_q != '0) && (cnt_q != CNT_W'(DATA_W))) begin
      {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
      cnt_q          <= cnt_q + CNT_W'(1);
    end
  end

  assign bcd  = bcd_q;
  assign done = (cnt_q == CNT_W'(DATA_W));

endmodule
`endif

// File: rtl/syscall_unit.sv
// SYSCALL responder beside EX: stalls the pipe, prints int/char on a byte stream, exits.
// Optional print_int path (converter, SIGN/DIGITS) is built under SYSCALL_PRINT_INT_EN.
module syscall_unit
  import syscall_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              sys,
  input  logic [DATA_W-1:0] v0,
  input  logic [DATA_W-1:0] a0,
  output logic              stall,
  output logic              halt,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  state_t            state_q, state_d;
  logic              tx_valid_d;
  logic [BYTE_W-1:0] tx_data_d;
  logic              xfer;

  assign xfer = tx_valid && tx_ready;

`ifdef SYSCALL_PRINT_INT_EN
  logic              neg_q, neg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              conv_start;
  logic              conv_done;
  logic [DATA_W-1:0] mag;
  logic [BCD_W-1:0]  bcd;

  // Unsigned magnitude; 0x80000000 maps onto itself as 2147483648.
  assign mag = a0[DATA_W-1] ? (~a0 + DATA_W'(1)) : a0;

  bin2bcd_serial u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .value (mag),
    .bcd   (bcd),
    .done  (conv_done)
  );
`else
  logic unused_a0;
  assign unused_a0 = ^a0[DATA_W-1:BYTE_W];
`endif

  // Next-state, stall and next-byte logic.
  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    tx_valid_d = tx_valid;
    tx_data_d  = tx_data;
`ifdef SYSCALL_PRINT_INT_EN
    neg_d      = neg_q;
    idx_d      = idx_q;
    conv_start = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (sys) begin
`ifdef SYSCALL_PRINT_INT_EN
          if (v0 == SYS_PRINT_INT) begin
            state_d    = ST_CONV;
            stall      = 1'b1;
            conv_start = 1'b1;
            neg_d      = a0[DATA_W-1];
          end else
`endif
          if (v0 == SYS_PRINT_CHAR) begin
            state_d    = ST_CHAR;
            stall      = 1'b1;
            tx_valid_d = 1'b1;
            tx_data_d  = a0[BYTE_W-1:0];
          end else if (v0 == SYS_EXIT) begin
            state_d = ST_HALTED;
            stall   = 1'b1;
          end
        end
      end
`ifdef SYSCALL_PRINT_INT_EN
      ST_CONV: begin
        stall = 1'b1;
        if (conv_done) begin
          idx_d      = top_index(bcd);
          tx_valid_d = 1'b1;
          if (neg_q) begin
            state_d   = ST_SIGN;
            tx_data_d = ASCII_MINUS;
          end else begin
            state_d   = ST_DIGITS;
            tx_data_d = ascii_digit(bcd_digit(bcd, top_index(bcd)));
          end
        end
      end
      ST_SIGN: begin
        stall = 1'b1;
        if (xfer) begin
          state_d   = ST_DIGITS;
          tx_data_d = ascii_digit(bcd_digit(bcd, idx_q));
        end
      end
      ST_DIGITS: begin
        stall = 1'b1;
        if (xfer) begin
          if (idx_q == '0) begin
            state_d    = ST_DONE;
            tx_valid_d = 1'b0;
          end else begin
            idx_d     = idx_q - IDX_W'(1);
            tx_data_d = ascii_digit(bcd_digit(bcd, idx_q - IDX_W'(1)));
          end
        end
      end
`endif
      ST_CHAR: begin
        stall = 1'b1;
        if (xfer) begin
          state_d    = ST_DONE;
          tx_valid_d = 1'b0;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      ST_HALTED: stall   = 1'b1;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      halt     <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_valid <= tx_valid_d;
      tx_data  <= tx_data_d;
      halt     <= (state_d == ST_HALTED);
    end
  end

`ifdef SYSCALL_PRINT_INT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_q <= 1'b0;
      idx_q <= '0;
    end else begin
      neg_q <= neg_d;
      idx_q <= idx_d;
    end
  end
`endif

endmodule
